// File: rtl/conv2d_mac_ctrl_if.sv
// Result stream of the convolution sequencer.
// Handshake: a beat transfers on a rising clk edge where output_valid && output_ready;
// once raised, output_valid and output_data hold steady until that transfer.
interface conv2d_mac_ctrl_if #(
  parameter int OUTW = 64
);
  logic [OUTW-1:0] output_data;
  logic            output_valid;
  logic            output_ready;

  modport master (output output_data, output output_valid, input output_ready);
  modport slave  (input output_data, input output_valid, output output_ready);
endinterface

// File: rtl/conv2d_mac_ctrl.sv
// Sequencer that walks a valid-mode 2D convolution through one mac_pipe,
// reading X/W from synchronous memories and streaming each finished pixel out.
module conv2d_mac_ctrl #(
  parameter int INW  = 16,
  parameter int OUTW = 64,
  parameter int R    = 8,
  parameter int C    = 8,
  parameter int K    = 3,
  parameter int XAW  = $clog2(R*C),
  parameter int WAW  = $clog2(K*K)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic signed [INW-1:0]  bias,
  output logic                   busy,
  output logic                   done,
  output logic [XAW-1:0]         x_addr,
  input  logic signed [INW-1:0]  x_data,
  output logic [WAW-1:0]         w_addr,
  input  logic signed [INW-1:0]  w_data,
  output logic signed [INW-1:0]  mac_input0,
  output logic signed [INW-1:0]  mac_input1,
  output logic signed [INW-1:0]  mac_init_value,
  output logic                   mac_init_acc,
  output logic                   mac_input_valid,
  input  logic signed [OUTW-1:0] mac_out,
  output logic [2:0]             dbg_state,
  conv2d_mac_ctrl_if.master      out_if
);

  localparam int RW = $clog2(R + 1);
  localparam int CW = $clog2(C + 1);
  localparam int KW = $clog2(K + 1);

  localparam logic [RW-1:0]  R_LAST   = RW'(R - K);
  localparam logic [CW-1:0]  C_LAST   = CW'(C - K);
  localparam logic [KW-1:0]  K_LAST   = KW'(K - 1);
  localparam logic [KW-1:0]  K_ONE    = KW'(1);
  localparam logic [RW-1:0]  R_ONE    = RW'(1);
  localparam logic [CW-1:0]  C_ONE    = CW'(1);
  localparam logic [XAW-1:0] X_ONE    = XAW'(1);
  localparam logic [XAW-1:0] X_K      = XAW'(K);
  localparam logic [XAW-1:0] ROW_STEP = XAW'(C - K + 1);
  localparam logic [WAW-1:0] W_ONE    = WAW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t         state;
  logic [RW-1:0]  r;
  logic [CW-1:0]  c;
  logic [KW-1:0]  i;
  logic [KW-1:0]  j;
  logic [XAW-1:0] pix_addr;
  logic           drain_2nd;
  logic           out_valid;
  logic           last_tap;

  // (i, j) is the tap whose addresses are on x_addr/w_addr this cycle.
  assign last_tap   = (i == K_LAST) && (j == K_LAST);
  assign mac_input0 = x_data;
  assign mac_input1 = w_data;
  assign dbg_state  = state;

  assign out_if.output_valid = out_valid;
  assign out_if.output_data  = out_valid ? mac_out : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      r               <= '0;
      c               <= '0;
      i               <= '0;
      j               <= '0;
      pix_addr        <= '0;
      drain_2nd       <= 1'b0;
      out_valid       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      x_addr          <= '0;
      w_addr          <= '0;
      mac_init_value  <= '0;
      mac_init_acc    <= 1'b0;
      mac_input_valid <= 1'b0;
    end else begin
      done            <= 1'b0;
      mac_init_acc    <= 1'b0;
      mac_input_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mac_init_value <= bias;
            r              <= '0;
            c              <= '0;
            i              <= '0;
            j              <= '0;
            pix_addr       <= '0;
            x_addr         <= '0;
            w_addr         <= '0;
            mac_init_acc   <= 1'b1;
            busy           <= 1'b1;
            state          <= S_INIT;
          end
        end
        S_INIT, S_FEED: begin
          // A read is on the bus this cycle, so its data arrives next cycle.
          mac_input_valid <= 1'b1;
          if (last_tap) begin
            drain_2nd <= 1'b0;
            state     <= S_DRAIN;
          end else begin
            state  <= S_FEED;
            w_addr <= w_addr + W_ONE;
            if (j == K_LAST) begin
              j      <= '0;
              i      <= i + K_ONE;
              x_addr <= x_addr + ROW_STEP;
            end else begin
              j      <= j + K_ONE;
              x_addr <= x_addr + X_ONE;
            end
          end
        end
        S_DRAIN: begin
          // Second cycle lets the MAC's delayed enable commit the last product.
          drain_2nd <= 1'b1;
          if (drain_2nd) begin
            out_valid <= 1'b1;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_valid && out_if.output_ready) begin
            out_valid <= 1'b0;
            i         <= '0;
            j         <= '0;
            w_addr    <= '0;
            if ((r == R_LAST) && (c == C_LAST)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              mac_init_acc <= 1'b1;
              state        <= S_INIT;
              if (c == C_LAST) begin
                c        <= '0;
                r        <= r + R_ONE;
                pix_addr <= pix_addr + X_K;
                x_addr   <= pix_addr + X_K;
              end else begin
                c        <= c + C_ONE;
                pix_addr <= pix_addr + X_ONE;
                x_addr   <= pix_addr + X_ONE;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_mac_ctrl.sv
// Bench for conv2d_mac_ctrl: memories and mac_pipe model around the DUT,
// a direct-convolution reference queue and a per-cycle compare process.
module tb_conv2d_mac_ctrl;
  localparam int INW  = 16;
  localparam int OUTW = 64;
  localparam int R    = 8;
  localparam int C    = 8;
  localparam int K    = 3;
  localparam int XAW  = $clog2(R*C);
  localparam int WAW  = $clog2(K*K);
  localparam int PIX  = K*K + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                   start = 1'b0;
  logic signed [INW-1:0]  bias = '0;
  logic                   busy, done;
  logic [XAW-1:0]         x_addr;
  logic signed [INW-1:0]  x_data;
  logic [WAW-1:0]         w_addr;
  logic signed [INW-1:0]  w_data;
  logic signed [INW-1:0]  mac_input0, mac_input1, mac_init_value;
  logic                   mac_init_acc, mac_input_valid;
  logic signed [OUTW-1:0] mac_out;
  logic [2:0]             dbg_state;

  conv2d_mac_ctrl_if #(.OUTW(OUTW)) out_if ();

  conv2d_mac_ctrl #(.INW(INW), .OUTW(OUTW), .R(R), .C(C), .K(K)) dut (
    .clk(clk), .reset(reset), .start(start), .bias(bias), .busy(busy), .done(done),
    .x_addr(x_addr), .x_data(x_data), .w_addr(w_addr), .w_data(w_data),
    .mac_input0(mac_input0), .mac_input1(mac_input1), .mac_init_value(mac_init_value),
    .mac_init_acc(mac_init_acc), .mac_input_valid(mac_input_valid), .mac_out(mac_out),
    .dbg_state(dbg_state), .out_if(out_if)
  );

  // ---------------- memories and MAC ----------------
  logic signed [INW-1:0] xmem [R*C];
  logic signed [INW-1:0] wmem [K*K];
  always @(posedge clk) begin
    x_data <= xmem[x_addr];
    w_data <= wmem[w_addr];
  end

  logic signed [2*INW-1:0] mac_prod;
  logic                    mac_en_d;
  always @(posedge clk) begin
    if (reset) begin
      mac_out  <= '0;
      mac_prod <= '0;
      mac_en_d <= 1'b0;
    end else begin
      mac_prod <= mac_input0 * mac_input1;
      mac_en_d <= mac_input_valid;
      if (mac_init_acc) mac_out <= OUTW'(mac_init_value);
      else if (mac_en_d) mac_out <= mac_out + OUTW'(mac_prod);
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [OUTW-1:0] exp_q[$];
  int n_expected;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic build_expected(input int b);
    logic signed [INW-1:0] b16;
    longint acc;
    b16 = INW'(b);
    exp_q.delete();
    for (int rr = 0; rr <= R-K; rr++)
      for (int cc = 0; cc <= C-K; cc++) begin
        acc = longint'(b16);
        for (int ii = 0; ii < K; ii++)
          for (int jj = 0; jj < K; jj++)
            acc += longint'(xmem[(rr+ii)*C + cc+jj]) * longint'(wmem[ii*K + jj]);
        exp_q.push_back(acc);
      end
    n_expected = exp_q.size();
  endtask

  // ---------------- per-cycle compare ----------------
  int t0 = 0;
  bit active = 1'b0;
  bit run_done = 1'b0;
  int hs_count, prev_hs, iv_count;
  bit was_pending;
  logic [OUTW-1:0] last_data;

  always @(negedge clk) begin
    int rel;
    rel = cyc - t0;
    if (active) begin
      if (mac_input_valid) iv_count++;
      if (mac_init_acc) chk("init_time", rel, prev_hs + 1);
      if (out_if.output_valid) begin
        if (!was_pending) begin
          chk("valid_time", rel, prev_hs + PIX);
          chk("taps_per_pixel", iv_count, K*K);
        end else
          chk("hold_data", out_if.output_data, last_data);
        if (exp_q.size() == 0) chk("extra_output", exp_q.size(), 1);
        else chk("output_data", out_if.output_data, exp_q[0]);
        if (!out_if.output_ready) begin
          chk("stall_init_acc", mac_init_acc, 0);
          chk("stall_input_valid", mac_input_valid, 0);
          was_pending = 1'b1;
        end else begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          hs_count++;
          prev_hs = rel;
          iv_count = 0;
          was_pending = 1'b0;
        end
        last_data = out_if.output_data;
      end else begin
        if (was_pending) chk("valid_held", out_if.output_valid, 1);
        chk("data_zero_when_invalid", out_if.output_data, 0);
        was_pending = 1'b0;
      end
      if (done) begin
        chk("done_time", rel, prev_hs + 1);
        chk("done_count", hs_count, n_expected);
        chk("busy_in_done", busy, 0);
        run_done = 1'b1;
        active = 1'b0;
      end else if (rel >= 1)
        chk("busy", busy, 1);
    end
  end

  // ---------------- ready driver ----------------
  int rmode = 0;
  int stall_left = 0;
  initial begin
    out_if.output_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        1: if (out_if.output_valid && stall_left > 0) begin
             out_if.output_ready = 1'b0;
             stall_left--;
           end else out_if.output_ready = 1'b1;
        2: out_if.output_ready = ($urandom_range(0, 3) != 0);
        default: out_if.output_ready = 1'b1;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, out_if.output_valid, 0);
    chk({tag, "_data"}, out_if.output_data, 0);
    chk({tag, "_init_acc"}, mac_init_acc, 0);
    chk({tag, "_input_valid"}, mac_input_valid, 0);
    chk({tag, "_x_addr"}, x_addr, 0);
    chk({tag, "_w_addr"}, w_addr, 0);
    chk({tag, "_init_value"}, mac_init_value, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // Runs one convolution against the prebuilt exp_q.
  task automatic run_conv(input int b, input int ready_mode, input bit inj_start, input int reset_pix);
    rmode = ready_mode;
    stall_left = 5;
    hs_count = 0; prev_hs = 0; iv_count = 0; was_pending = 1'b0; run_done = 1'b0;
    @(posedge clk); #1;
    bias = INW'(b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bias = INW'($urandom);
    t0 = cyc - 1;
    active = 1'b1;
    for (int k = 0; k < 4000 && !run_done; k++) begin
      @(posedge clk); #1;
      start = inj_start && ((cyc - t0) == 100);
      if (reset_pix >= 0 && hs_count == reset_pix && (cyc - t0) == prev_hs + 4) begin
        active = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_quiet("midrun_reset");
        return;
      end
    end
    start = 1'b0;
    if (!run_done) begin
      chk("run_timeout", run_done, 1);
      active = 1'b0;
    end
    chk("outputs_total", hs_count, n_expected);
    repeat (3) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int a = 0; a < R*C; a++) xmem[a] = '0;
    for (int a = 0; a < K*K; a++) wmem[a] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b0;
    check_quiet("after_reset");

    // Ones
    for (int a = 0; a < R*C; a++) xmem[a] = 16'sd1;
    for (int a = 0; a < K*K; a++) wmem[a] = 16'sd1;
    build_expected(0);
    chk("model_ones_size", exp_q.size(), 36);
    chk("model_ones_first", exp_q[0], 9);
    chk("model_ones_last", exp_q[35], 9);
    run_conv(0, 0, 1'b0, -1);

    // Signed, with a start pulse while busy
    for (int a = 0; a < R*C; a++) xmem[a] = -16'sd3;
    for (int a = 0; a < K*K; a++) wmem[a] = 16'sd2;
    build_expected(5);
    chk("model_signed", exp_q[7], -49);
    run_conv(5, 0, 1'b1, -1);

    // Full-scale products
    for (int a = 0; a < R*C; a++) xmem[a] = 16'sd32767;
    for (int a = 0; a < K*K; a++) wmem[a] = 16'sd32767;
    build_expected(-32768);
    chk("model_max", exp_q[20], 64'sd9663053833);
    run_conv(-32768, 0, 1'b0, -1);

    // Ramp through a centre-tap filter
    for (int a = 0; a < R*C; a++) xmem[a] = INW'(a);
    for (int a = 0; a < K*K; a++) wmem[a] = '0;
    wmem[K + 1] = 16'sd1;
    build_expected(0);
    chk("model_ramp0", exp_q[0], 9);
    chk("model_ramp5", exp_q[5], 14);
    chk("model_ramp6", exp_q[6], 17);
    chk("model_ramp35", exp_q[35], 54);
    run_conv(0, 0, 1'b0, -1);

    // Backpressure on the first result
    for (int a = 0; a < R*C; a++) xmem[a] = 16'sd1;
    for (int a = 0; a < K*K; a++) wmem[a] = 16'sd1;
    build_expected(0);
    run_conv(0, 1, 1'b0, -1);

    // Reset during FEED of the fifth pixel, then a fresh complete run
    for (int a = 0; a < R*C; a++) xmem[a] = INW'($urandom);
    for (int a = 0; a < K*K; a++) wmem[a] = INW'($urandom);
    build_expected(123);
    run_conv(123, 0, 1'b0, 4);
    repeat (2) @(posedge clk);
    build_expected(123);
    run_conv(123, 0, 1'b0, -1);

    // Random data and random ready
    for (int n = 0; n < 3; n++) begin
      int b;
      for (int a = 0; a < R*C; a++) xmem[a] = INW'($urandom);
      for (int a = 0; a < K*K; a++) wmem[a] = INW'($urandom);
      b = $signed(INW'($urandom));
      build_expected(b);
      run_conv(b, 2, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
